// File: rtl/control_unit.sv
// Sequencer for a small register-file processor: decodes IR into bus-drive and load strobes.
// Latency: Done one cycle after Run for mv/mvi/undefined, three cycles for add/sub; no backpressure.
module control_unit (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_run,
    input  logic [8:0] i_ir,
    output logic       o_irin,
    output logic [7:0] o_rin,
    output logic [7:0] o_rout,
    output logic       o_ain,
    output logic       o_gin,
    output logic       o_gout,
    output logic       o_dinout,
    output logic       o_addsub,
    output logic       o_done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_op;
    logic [2:0] w_x;
    logic [2:0] w_y;
    logic [7:0] w_x_oh;
    logic [7:0] w_y_oh;

    assign w_op   = i_ir[8:6];
    assign w_x    = i_ir[5:3];
    assign w_y    = i_ir[2:0];
    assign w_x_oh = 8'd1 << w_x;
    assign w_y_oh = 8'd1 << w_y;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= T0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = T0;
        o_irin   = 1'b0;
        o_rin    = 8'd0;
        o_rout   = 8'd0;
        o_ain    = 1'b0;
        o_gin    = 1'b0;
        o_gout   = 1'b0;
        o_dinout = 1'b0;
        o_addsub = 1'b0;
        o_done   = 1'b0;
        case (r_state)
            T0: begin
                o_irin = i_run;
                w_next = i_run ? T1 : T0;
            end
            T1: begin
                case (w_op)
                    OP_MV: begin
                        o_rout = w_y_oh;
                        o_rin  = w_x_oh;
                        o_done = 1'b1;
                    end
                    OP_MVI: begin
                        o_dinout = 1'b1;
                        o_rin    = w_x_oh;
                        o_done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        o_rout = w_x_oh;
                        o_ain  = 1'b1;
                        w_next = T2;
                    end
                    default: o_done = 1'b1;
                endcase
            end
            T2: begin
                o_rout   = w_y_oh;
                o_gin    = 1'b1;
                o_addsub = (w_op == OP_SUB);
                w_next   = T3;
            end
            T3: begin
                o_gout = 1'b1;
                o_rin  = w_x_oh;
                o_done = 1'b1;
            end
            default: w_next = T0;
        endcase
        // Reset silences every strobe in the same cycle so an aborted instruction writes nothing.
        if (i_reset) begin
            w_next   = T0;
            o_irin   = 1'b0;
            o_rin    = 8'd0;
            o_rout   = 8'd0;
            o_ain    = 1'b0;
            o_gin    = 1'b0;
            o_gout   = 1'b0;
            o_dinout = 1'b0;
            o_addsub = 1'b0;
            o_done   = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomised and directed bench for control_unit against a queue-based instruction model.
module tb_control_unit;

    typedef struct packed {
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic       dinout;
        logic       addsub;
        logic       done;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [8:0] ir_reg = 9'd0;

    logic       o_irin, o_ain, o_gin, o_gout, o_dinout, o_addsub, o_done;
    logic [7:0] o_rin, o_rout;
    out_t       obs;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;
    logic prev_done = 1'b0;

    out_t exp_q[$];

    always #5 clk = ~clk;

    control_unit dut (
        .i_clock  (clk),
        .i_reset  (rst),
        .i_run    (run),
        .i_ir     (ir_reg),
        .o_irin   (o_irin),
        .o_rin    (o_rin),
        .o_rout   (o_rout),
        .o_ain    (o_ain),
        .o_gin    (o_gin),
        .o_gout   (o_gout),
        .o_dinout (o_dinout),
        .o_addsub (o_addsub),
        .o_done   (o_done)
    );

    assign obs = {o_irin, o_rin, o_rout, o_ain, o_gin, o_gout, o_dinout, o_addsub, o_done};

    // Reference: an accepted instruction expands into its list of per-cycle strobe sets.
    task automatic push_instr(input logic [8:0] w);
        logic [2:0] op, x, y;
        out_t a;
        op = w[8:6];
        x  = w[5:3];
        y  = w[2:0];
        a  = '0;
        if (op == 3'd0) begin
            a.rout = 8'd1 << y; a.rin = 8'd1 << x; a.done = 1'b1;
            exp_q.push_back(a);
        end else if (op == 3'd1) begin
            a.dinout = 1'b1; a.rin = 8'd1 << x; a.done = 1'b1;
            exp_q.push_back(a);
        end else if (op == 3'd2 || op == 3'd3) begin
            a.rout = 8'd1 << x; a.ain = 1'b1;
            exp_q.push_back(a);
            a = '0;
            a.rout = 8'd1 << y; a.gin = 1'b1; a.addsub = (op == 3'd3);
            exp_q.push_back(a);
            a = '0;
            a.gout = 1'b1; a.rin = 8'd1 << x; a.done = 1'b1;
            exp_q.push_back(a);
        end else begin
            a.done = 1'b1;
            exp_q.push_back(a);
        end
    endtask

    task automatic model_step(input logic r, input logic rs, input logic [8:0] din, output out_t e);
        e = '0;
        if (rs) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e.irin = r;
            if (r) push_instr(din);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 ns later, load IR on the rising edge.
    task automatic step(input logic r, input logic rs, input logic [8:0] din,
                        output out_t o, output out_t e);
        @(negedge clk);
        run = r;
        rst = rs;
        #1;
        o = obs;
        model_step(r, rs, din, e);
        @(posedge clk);
        if (o.irin) ir_reg = din;
    endtask

    always begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            n_checks++;
            if ($countones({o_rout, o_gout, o_dinout}) > 1) begin
                n_errors++;
                $display("FAIL bus_onehot: drives=%b rout=%b gout=%b dinout=%b required at most one", 
                         {o_rout, o_gout, o_dinout}, o_rout, o_gout, o_dinout);
            end
            n_checks++;
            if ((|o_rin || o_ain || o_gin) && $countones({o_rout, o_gout, o_dinout}) != 1) begin
                n_errors++;
                $display("FAIL bus_driven_on_load: drives=%b required exactly one", {o_rout, o_gout, o_dinout});
            end
            n_checks++;
            if ($countones(o_rin) > 1) begin
                n_errors++;
                $display("FAIL rin_onehot: rin=%b required at most one bit", o_rin);
            end
            n_checks++;
            if (prev_done && o_done) begin
                n_errors++;
                $display("FAIL done_pulse: done=1 in consecutive cycles, required single-cycle pulse");
            end
            prev_done = o_done;
        end
    end

    task automatic test_reset;
        out_t o, e;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 9'h0, o, e);
            n_checks++;
            if (o !== out_t'(0)) begin
                n_errors++;
                $display("FAIL reset_outputs: got %h required 0", o);
            end
        end
        mon_en = 1'b1;
        step(1'b0, 1'b0, 9'h0, o, e);
        n_checks++;
        if (o !== out_t'(0) || o !== e) begin
            n_errors++;
            $display("FAIL reset_idle: got %h required %h", o, e);
        end
    endtask

    task automatic test_mvi;
        out_t o, e;
        step(1'b1, 1'b0, 9'b001_010_000, o, e);
        n_checks++;
        if (o.irin !== 1'b1 || o !== e) begin
            n_errors++;
            $display("FAIL mvi_t0: got %h required %h", o, e);
        end
        step(1'b0, 1'b0, 9'h0, o, e);
        n_checks++;
        if (o.dinout !== 1'b1 || o.rin !== 8'b0000_0100 || o.done !== 1'b1 || o !== e) begin
            n_errors++;
            $display("FAIL mvi_t1: got %h required %h", o, e);
        end
        step(1'b0, 1'b0, 9'h0, o, e);
        n_checks++;
        if (o !== out_t'(0)) begin
            n_errors++;
            $display("FAIL mvi_back_to_t0: got %h required 0", o);
        end
    endtask

    task automatic test_add;
        out_t o, e;
        step(1'b1, 1'b0, 9'b010_001_101, o, e);
        step(1'b0, 1'b0, 9'h0, o, e);
        n_checks++;
        if (o.rout !== 8'b0000_0010 || o.ain !== 1'b1 || o !== e) begin
            n_errors++;
            $display("FAIL add_t1: got %h required %h", o, e);
        end
        step(1'b0, 1'b0, 9'h0, o, e);
        n_checks++;
        if (o.rout !== 8'b0010_0000 || o.gin !== 1'b1 || o.addsub !== 1'b0 || o !== e) begin
            n_errors++;
            $display("FAIL add_t2: got %h required %h", o, e);
        end
        step(1'b0, 1'b0, 9'h0, o, e);
        n_checks++;
        if (o.gout !== 1'b1 || o.rin !== 8'b0000_0010 || o.done !== 1'b1 || o !== e) begin
            n_errors++;
            $display("FAIL add_t3: got %h required %h", o, e);
        end
    endtask

    task automatic test_sub_run_held;
        out_t o, e;
        step(1'b1, 1'b0, 9'b011_111_000, o, e);
        step(1'b1, 1'b0, 9'b011_111_000, o, e);
        n_checks++;
        if (o.irin !== 1'b0 || o !== e) begin
            n_errors++;
            $display("FAIL sub_t1: got %h required %h", o, e);
        end
        step(1'b1, 1'b0, 9'b011_111_000, o, e);
        n_checks++;
        if (o.rout !== 8'b0000_0001 || o.addsub !== 1'b1 || o.irin !== 1'b0 || o !== e) begin
            n_errors++;
            $display("FAIL sub_t2: got %h required %h", o, e);
        end
        step(1'b1, 1'b0, 9'b011_111_000, o, e);
        n_checks++;
        if (o.rin !== 8'b1000_0000 || o.done !== 1'b1 || o.irin !== 1'b0 || o !== e) begin
            n_errors++;
            $display("FAIL sub_t3: got %h required %h", o, e);
        end
        step(1'b1, 1'b0, 9'b000_001_010, o, e);
        n_checks++;
        if (o.irin !== 1'b1 || o.done !== 1'b0 || o !== e) begin
            n_errors++;
            $display("FAIL sub_restart_t0: got %h required %h", o, e);
        end
        step(1'b0, 1'b0, 9'h0, o, e);
        n_checks++;
        if (o !== e) begin
            n_errors++;
            $display("FAIL sub_followup_mv: got %h required %h", o, e);
        end
    endtask

    task automatic test_reset_mid;
        out_t o, e;
        step(1'b1, 1'b0, 9'b010_001_101, o, e);
        step(1'b0, 1'b0, 9'h0, o, e);
        step(1'b1, 1'b1, 9'h0, o, e);
        n_checks++;
        if (o !== out_t'(0) || o !== e) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got %h required 0", o);
        end
        step(1'b0, 1'b0, 9'h0, o, e);
        n_checks++;
        if (o.done !== 1'b0 || o.rin !== 8'd0 || o !== e) begin
            n_errors++;
            $display("FAIL reset_mid_abort: got %h required %h", o, e);
        end
        step(1'b1, 1'b0, 9'b000_100_100, o, e);
        step(1'b0, 1'b0, 9'h0, o, e);
        n_checks++;
        if (o.rout !== 8'b0001_0000 || o.rin !== 8'b0001_0000 || o.done !== 1'b1 || o !== e) begin
            n_errors++;
            $display("FAIL mv_r4_r4: got %h required %h", o, e);
        end
    endtask

    task automatic test_undef;
        out_t o, e, u;
        u = '0;
        u.done = 1'b1;
        step(1'b1, 1'b0, 9'b110_011_001, o, e);
        step(1'b0, 1'b0, 9'h0, o, e);
        n_checks++;
        if (o !== u || o !== e) begin
            n_errors++;
            $display("FAIL undef_t1: got %h required %h", o, u);
        end
        step(1'b0, 1'b0, 9'h0, o, e);
        n_checks++;
        if (o !== out_t'(0)) begin
            n_errors++;
            $display("FAIL undef_back_to_t0: got %h required 0", o);
        end
    endtask

    task automatic test_random;
        out_t o, e;
        logic r, rs;
        logic [8:0] din;
        for (int i = 0; i < 600; i++) begin
            rs  = ($urandom_range(0, 39) == 0);
            r   = $urandom_range(0, 2) != 0;
            din = 9'($urandom);
            step(r, rs, din, o, e);
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL random_cycle%0d: got %h required %h", i, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_add();
        test_sub_run_held();
        test_reset_mid();
        test_undef();
        test_random();
        @(negedge clk);
        mon_en = 1'b0;
        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
